// File: rtl/update_the_stopwatch.sv
// ---------------------------------------------------------------------------
// update_the_stopwatch
//
// Four-digit decimal stopwatch (00.00 .. 99.99 s, 10 ms resolution) that
// drives a four-digit common-anode seven-segment display by time-multiplexed
// scanning and exports the raw BCD digits for debug.
//
// Parameters:
//   TICK_DIV      clock cycles per count step (10 ms at 100 MHz)
//   REFRESH_BITS  width of the free-running scan counter; top 2 bits pick
//                 the digit being displayed
//
// Ports:
//   clk_100_Mhz                in   system clock, rising-edge
//   reset                      in   synchronous, active-low clear
//   start                      in   level run enable (1 = count, 0 = pause)
//   third_hex_digit            out  tens of seconds (BCD)
//   second_hex_digit           out  seconds (BCD)
//   first_hex_digit            out  tenths (BCD)
//   zero_hex_digit             out  hundredths (BCD)
//   anode_bits                 out  digit enables, active-low, bit 3 = left
//   seven_segments_LED_output  out  {a..g}, active-low, bit 6 = a
//   LED_binary_coded_decimal   out  digit currently routed to the decoder
//   decimal_point              out  active-low, lit after the seconds digit
//
// Optional feature macro: STOPWATCH_BLANK_LEADING_ZERO_EN
//   When defined, the leftmost digit is dark while it holds 0.
// ---------------------------------------------------------------------------
module update_the_stopwatch #(
    parameter int TICK_DIV     = 1_000_000,
    parameter int REFRESH_BITS = 20
) (
    input  logic       clk_100_Mhz,
    input  logic       reset,
    input  logic       start,
    output logic [3:0] third_hex_digit,
    output logic [3:0] second_hex_digit,
    output logic [3:0] first_hex_digit,
    output logic [3:0] zero_hex_digit,
    output logic [3:0] anode_bits,
    output logic [6:0] seven_segments_LED_output,
    output logic [3:0] LED_binary_coded_decimal,
    output logic       decimal_point
);

    localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]           prescaler;
    logic [REFRESH_BITS-1:0] refresh_count;
    logic [1:0]              sel;
    logic                    step;
    logic                    carry_1;
    logic                    carry_2;
    logic                    carry_3;

    // A step needs start high on the same edge, so dropping start blocks a
    // step that would otherwise have fired.
    assign step    = start && (prescaler == TICK_LAST);
    assign carry_1 = step    && (zero_hex_digit   == 4'd9);
    assign carry_2 = carry_1 && (first_hex_digit  == 4'd9);
    assign carry_3 = carry_2 && (second_hex_digit == 4'd9);

    assign sel = refresh_count[REFRESH_BITS-1 -: 2];

    function automatic logic [3:0] bcd_next(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    // Prescaler holds while paused so a pause keeps the partial step.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of its neighbours, regardless of statement order.
    always_ff @(posedge clk_100_Mhz) begin
        if (!reset) begin
            prescaler <= '0;
        end else if (start) begin
            prescaler <= step ? '0 : prescaler + 1'b1;
        end
    end

    // BCD cascade; the carry out of the tens-of-seconds digit is dropped, so
    // 99.99 wraps to 00.00 and keeps running. Reset wins over a step.
    always_ff @(posedge clk_100_Mhz) begin
        if (!reset) begin
            zero_hex_digit   <= 4'd0;
            first_hex_digit  <= 4'd0;
            second_hex_digit <= 4'd0;
            third_hex_digit  <= 4'd0;
        end else begin
            if (step)    zero_hex_digit   <= bcd_next(zero_hex_digit);
            if (carry_1) first_hex_digit  <= bcd_next(first_hex_digit);
            if (carry_2) second_hex_digit <= bcd_next(second_hex_digit);
            if (carry_3) third_hex_digit  <= bcd_next(third_hex_digit);
        end
    end

    // Free-running scan counter, independent of start.
    always_ff @(posedge clk_100_Mhz) begin
        if (!reset) begin
            refresh_count <= '0;
        end else begin
            refresh_count <= refresh_count + 1'b1;
        end
    end

    // Digit select / anode drive.
    // NOTE: every output of an always_comb gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        anode_bits               = 4'b1111;
        LED_binary_coded_decimal = third_hex_digit;
        decimal_point            = 1'b1;
        case (sel)
            2'd0: begin
                anode_bits               = 4'b0111;
                LED_binary_coded_decimal = third_hex_digit;
`ifdef STOPWATCH_BLANK_LEADING_ZERO_EN
                if (third_hex_digit == 4'd0) anode_bits = 4'b1111;
`endif
            end
            2'd1: begin
                anode_bits               = 4'b1011;
                LED_binary_coded_decimal = second_hex_digit;
                decimal_point            = 1'b0;
            end
            2'd2: begin
                anode_bits               = 4'b1101;
                LED_binary_coded_decimal = first_hex_digit;
            end
            default: begin
                anode_bits               = 4'b1110;
                LED_binary_coded_decimal = zero_hex_digit;
            end
        endcase
    end

    // Active-low segment decode, {a,b,c,d,e,f,g}.
    always_comb begin
        seven_segments_LED_output = 7'b1111111;
        case (LED_binary_coded_decimal)
            4'd0:    seven_segments_LED_output = 7'b0000001;
            4'd1:    seven_segments_LED_output = 7'b1001111;
            4'd2:    seven_segments_LED_output = 7'b0010010;
            4'd3:    seven_segments_LED_output = 7'b0000110;
            4'd4:    seven_segments_LED_output = 7'b1001100;
            4'd5:    seven_segments_LED_output = 7'b0100100;
            4'd6:    seven_segments_LED_output = 7'b0100000;
            4'd7:    seven_segments_LED_output = 7'b0001111;
            4'd8:    seven_segments_LED_output = 7'b0000000;
            4'd9:    seven_segments_LED_output = 7'b0000100;
            default: seven_segments_LED_output = 7'b1111111;
        endcase
    end

endmodule

// File: tb/tb_update_the_stopwatch.sv
// ---------------------------------------------------------------------------
// tb_update_the_stopwatch
//
// Directed bench for update_the_stopwatch with TICK_DIV=4, REFRESH_BITS=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// A small cycle model (prescaler, count in hundredths, scan counter) supplies
// expected display values alongside hand-computed digit checkpoints.
// ---------------------------------------------------------------------------
module tb_update_the_stopwatch;

    localparam int TICK_DIV     = 4;
    localparam int REFRESH_BITS = 4;

    logic       clk_100_Mhz = 1'b0;
    logic       reset       = 1'b0;
    logic       start       = 1'b0;
    logic [3:0] third_hex_digit;
    logic [3:0] second_hex_digit;
    logic [3:0] first_hex_digit;
    logic [3:0] zero_hex_digit;
    logic [3:0] anode_bits;
    logic [6:0] seven_segments_LED_output;
    logic [3:0] LED_binary_coded_decimal;
    logic       decimal_point;

    int tests_run = 0;
    int tests_failed = 0;

    // Cycle model state.
    int m_pre = 0;
    int m_val = 0;
    int m_ref = 0;

    update_the_stopwatch #(
        .TICK_DIV     (TICK_DIV),
        .REFRESH_BITS (REFRESH_BITS)
    ) dut (
        .clk_100_Mhz               (clk_100_Mhz),
        .reset                     (reset),
        .start                     (start),
        .third_hex_digit           (third_hex_digit),
        .second_hex_digit          (second_hex_digit),
        .first_hex_digit           (first_hex_digit),
        .zero_hex_digit            (zero_hex_digit),
        .anode_bits                (anode_bits),
        .seven_segments_LED_output (seven_segments_LED_output),
        .LED_binary_coded_decimal  (LED_binary_coded_decimal),
        .decimal_point             (decimal_point)
    );

    always #5 clk_100_Mhz = ~clk_100_Mhz;

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int seg_of(input int v);
        case (v)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int m_digit(input int k);
        int v;
        v = m_val;
        for (int i = 0; i < k; i++) v = v / 10;
        return v % 10;
    endfunction

    function automatic int m_sel();
        return (m_ref >> (REFRESH_BITS - 2)) & 3;
    endfunction

    function automatic int exp_shown();
        return m_digit(3 - m_sel());
    endfunction

    function automatic int exp_anode();
        case (m_sel())
            0: begin
`ifdef STOPWATCH_BLANK_LEADING_ZERO_EN
                if (m_digit(3) == 0) return 4'b1111;
`endif
                return 4'b0111;
            end
            1: return 4'b1011;
            2: return 4'b1101;
            default: return 4'b1110;
        endcase
    endfunction

    // Number of outputs disagreeing with the model right now.
    function automatic int model_errs();
        int e;
        e = 0;
        if (zero_hex_digit   !== 4'(m_digit(0))) e++;
        if (first_hex_digit  !== 4'(m_digit(1))) e++;
        if (second_hex_digit !== 4'(m_digit(2))) e++;
        if (third_hex_digit  !== 4'(m_digit(3))) e++;
        if (anode_bits !== 4'(exp_anode())) e++;
        if (LED_binary_coded_decimal !== 4'(exp_shown())) e++;
        if (seven_segments_LED_output !== 7'(seg_of(exp_shown()))) e++;
        if (decimal_point !== (m_sel() != 1)) e++;
        return e;
    endfunction

    function automatic int range_errs();
        int e;
        e = 0;
        if (zero_hex_digit   > 4'd9) e++;
        if (first_hex_digit  > 4'd9) e++;
        if (second_hex_digit > 4'd9) e++;
        if (third_hex_digit  > 4'd9) e++;
        return e;
    endfunction

    // One clock: the model advances with the inputs seen at the rising edge,
    // then the bench waits for the falling edge to sample.
    task automatic cycle();
        @(posedge clk_100_Mhz);
        if (!reset) begin
            m_pre = 0;
            m_val = 0;
            m_ref = 0;
        end else begin
            m_ref = (m_ref + 1) % (1 << REFRESH_BITS);
            if (start) begin
                if (m_pre == TICK_DIV - 1) begin
                    m_pre = 0;
                    m_val = (m_val + 1) % 10000;
                end else begin
                    m_pre++;
                end
            end
        end
        @(negedge clk_100_Mhz);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic check_digits(input string tag, input int d3, input int d2,
                                input int d1, input int d0);
        check({tag, "_d3"}, third_hex_digit,  d3);
        check({tag, "_d2"}, second_hex_digit, d2);
        check({tag, "_d1"}, first_hex_digit,  d1);
        check({tag, "_d0"}, zero_hex_digit,   d0);
    endtask

    initial begin
        int errs;
        errs = 0;

        // Reset held with start=1: nothing counts.
        reset = 1'b0;
        start = 1'b1;
        run(2);
        check_digits("reset", 0, 0, 0, 0);
        check("reset_anode", anode_bits, 4'b0111);
        check("reset_seg", seven_segments_LED_output, 7'b0000001);
        check("reset_dp", decimal_point, 1);
        check("reset_bcd", LED_binary_coded_decimal, 0);

        // First step lands on the TICK_DIV-th edge after release.
        reset = 1'b1;
        run(3);
        check("first_step_early_d0", zero_hex_digit, 0);
        run(1);
        check("first_step_d0", zero_hex_digit, 1);
        for (int i = 0; i < 36; i++) begin
            cycle();
            errs += range_errs() + model_errs();
        end
        check_digits("count40", 0, 0, 1, 0);

        // Pause mid-step (prescaler at 2), then resume: step after 2 edges.
        run(2);
        start = 1'b0;
        run(100);
        check_digits("paused", 0, 0, 1, 0);
        start = 1'b1;
        run(1);
        check("resume_early_d0", zero_hex_digit, 0);
        run(1);
        check("resume_step_d0", zero_hex_digit, 1);

        // start dropped on the edge that would have stepped: no step.
        run(3);
        start = 1'b0;
        run(1);
        check("start_fall_no_step", zero_hex_digit, 1);
        start = 1'b1;
        run(1);
        check("start_fall_resume", zero_hex_digit, 2);

        // Scan with the count frozen at 00.12.
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            check("scan_anode", anode_bits, exp_anode());
            check("scan_bcd", LED_binary_coded_decimal, exp_shown());
            check("scan_seg", seven_segments_LED_output, seg_of(exp_shown()));
            check("scan_dp", decimal_point, (anode_bits == 4'b1011) ? 0 : 1);
        end

        // Mid-run reset at 12.34.
        reset = 1'b0;
        run(1);
        reset = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 1234 * TICK_DIV; i++) begin
            cycle();
            errs += range_errs() + model_errs();
        end
        check_digits("at_1234", 1, 2, 3, 4);
        reset = 1'b0;
        run(1);
        check_digits("midrun_reset", 0, 0, 0, 0);
        reset = 1'b1;
        run(3);
        check("restart_early_d0", zero_hex_digit, 0);
        run(1);
        check("restart_step_d0", zero_hex_digit, 1);

        // Wrap 99.99 -> 00.00 -> 00.01.
        reset = 1'b0;
        run(1);
        reset = 1'b1;
        for (int i = 0; i < 9999 * TICK_DIV; i++) begin
            cycle();
            errs += range_errs() + model_errs();
        end
        check_digits("at_9999", 9, 9, 9, 9);
        run(TICK_DIV);
        check_digits("wrap", 0, 0, 0, 0);
        run(TICK_DIV);
        check_digits("after_wrap", 0, 0, 0, 1);
        check("model_errs", errs, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
